// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned FLAG_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } ctrlState_t;

    localparam logic [SEL_W-1:0] IMM_NONE = 2'b00;
    localparam logic [SEL_W-1:0] IMM_DP   = 2'b01;
    localparam logic [SEL_W-1:0] IMM_MEM  = 2'b10;
    localparam logic [SEL_W-1:0] IMM_BR   = 2'b11;

    localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
    localparam logic [SEL_W-1:0] ALU_AND = 2'b10;
    localparam logic [SEL_W-1:0] ALU_ORR = 2'b11;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Extension format implied by the instruction class.
    function automatic logic [SEL_W-1:0] immFromOp(input logic [1:0] op);
        case (op)
            OP_DP:   return IMM_DP;
            OP_MEM:  return IMM_MEM;
            OP_BR:   return IMM_BR;
            default: return IMM_NONE;
        endcase
    endfunction
endpackage

// File: rtl/arm_multicycle_ctrl_if.sv
// Instruction fields in, datapath controls out, between controller and datapath.
interface arm_multicycle_ctrl_if;
    import arm_ctrl_pkg::*;

    logic [3:0]        Cond;
    logic [1:0]        Op;
    logic [5:0]        Funct;
    logic [3:0]        Rd;
    logic [FLAG_W-1:0] ALUFlags;

    logic              PCWrite;
    logic              MemWrite;
    logic              RegWrite;
    logic              IRWrite;
    logic              AdrSrc;
    logic [SEL_W-1:0]  ResultSrc;
    logic              ALUSrcA;
    logic [SEL_W-1:0]  ALUSrcB;
    logic [SEL_W-1:0]  ImmSrc;
    logic [1:0]        RegSrc;
    logic [SEL_W-1:0]  ALUControl;
    logic [FLAG_W-1:0] Flags;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags
    );
endinterface

// File: rtl/arm_cond_check.sv
// Condition evaluation against the NZCV register, and the split NZ/CV flag update.
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    output logic              CondEx,
    output logic [FLAG_W-1:0] Flags
);
    logic n, z, c, v;
    assign {n, z, c, v} = Flags;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = !z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = !c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = !n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = !v;
            COND_HI: CondEx = c && !z;
            COND_LS: CondEx = !c || z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = !z && (n == v);
            COND_LE: CondEx = z || (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    // FlagW[1] updates N,Z; FlagW[0] updates C,V.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags <= '0;
        end else begin
            if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end
endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM main FSM, ALU decoder and conditional write gating.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    arm_multicycle_ctrl_if.master ctrl
);
    ctrlState_t       state, nextState;
    logic             condEx;
    logic [1:0]       flagW;
    logic             nextPc, branch, regWriteRaw, memWriteRaw, irWrite;
    logic             adrSrc, aluSrcA, pcs;
    logic [SEL_W-1:0] resultSrc, aluSrcB, immSrc, aluControl, aluDecCtrl;
    logic             cmdKnown, cmdArith, isCmp;
    logic [3:0]       cmd;

    assign cmd = ctrl.Funct[4:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= nextState;
    end

    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:    nextState = DECODE;
            DECODE: begin
                case (ctrl.Op)
                    OP_MEM:  nextState = MEMADR;
                    OP_DP:   nextState = ctrl.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   nextState = BRANCH;
                    default: nextState = FETCH;
                endcase
            end
            MEMADR:   nextState = ctrl.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  nextState = MEMWB;
            EXECUTER: nextState = ALUWB;
            EXECUTEI: nextState = ALUWB;
            default:  nextState = FETCH;
        endcase
    end

    // Unknown commands fall back to ADD with no flag update.
    always_comb begin
        aluDecCtrl = ALU_ADD;
        cmdKnown   = 1'b1;
        cmdArith   = 1'b0;
        isCmp      = 1'b0;
        case (cmd)
            CMD_ADD: cmdArith = 1'b1;
            CMD_SUB: begin aluDecCtrl = ALU_SUB; cmdArith = 1'b1; end
            CMD_AND: aluDecCtrl = ALU_AND;
            CMD_ORR: aluDecCtrl = ALU_ORR;
            CMD_CMP: begin aluDecCtrl = ALU_SUB; cmdArith = 1'b1; isCmp = 1'b1; end
            default: cmdKnown = 1'b0;
        endcase
    end

    always_comb begin
        nextPc      = 1'b0;
        branch      = 1'b0;
        regWriteRaw = 1'b0;
        memWriteRaw = 1'b0;
        irWrite     = 1'b0;
        adrSrc      = 1'b0;
        resultSrc   = RES_ALURESULT;
        aluSrcA     = 1'b1;
        aluSrcB     = SRCB_FOUR;
        immSrc      = IMM_NONE;
        aluControl  = ALU_ADD;
        flagW       = 2'b00;
        case (state)
            FETCH:    begin irWrite = 1'b1; nextPc = 1'b1; end
            DECODE:   immSrc = immFromOp(ctrl.Op);
            MEMADR:   begin aluSrcA = 1'b0; aluSrcB = SRCB_IMM; immSrc = IMM_MEM; end
            MEMREAD:  begin adrSrc = 1'b1; resultSrc = RES_ALUOUT; end
            MEMWB:    begin resultSrc = RES_DATA; regWriteRaw = 1'b1; end
            MEMWRITE: begin adrSrc = 1'b1; memWriteRaw = 1'b1; end
            EXECUTER: begin aluSrcA = 1'b0; aluSrcB = SRCB_REG; aluControl = aluDecCtrl; end
            EXECUTEI: begin
                aluSrcA    = 1'b0;
                aluSrcB    = SRCB_IMM;
                immSrc     = IMM_DP;
                aluControl = aluDecCtrl;
            end
            ALUWB: begin
                resultSrc   = RES_ALUOUT;
                regWriteRaw = !isCmp;
                aluControl  = aluDecCtrl;
                flagW       = {2{ctrl.Funct[0] & condEx}} & {cmdKnown, cmdArith};
            end
            BRANCH: begin
                aluSrcA = 1'b0;
                aluSrcB = SRCB_IMM;
                immSrc  = IMM_BR;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are forced low while reset is held so nothing writes mid-reset.
    assign pcs            = branch | (regWriteRaw & (ctrl.Rd == 4'hF));
    assign ctrl.PCWrite   = reset_n & (nextPc | (pcs & condEx));
    assign ctrl.RegWrite  = reset_n & regWriteRaw & condEx;
    assign ctrl.MemWrite  = reset_n & memWriteRaw & condEx;
    assign ctrl.IRWrite   = reset_n & irWrite;
    assign ctrl.AdrSrc    = adrSrc;
    assign ctrl.ResultSrc = resultSrc;
    assign ctrl.ALUSrcA   = aluSrcA;
    assign ctrl.ALUSrcB   = aluSrcB;
    assign ctrl.ImmSrc    = immSrc;
    assign ctrl.ALUControl = aluControl;
    assign ctrl.RegSrc    = {(ctrl.Op == OP_MEM) & !ctrl.Funct[0], ctrl.Op == OP_BR};

    arm_cond_check uCondCheck (
        .clk      (clk),
        .reset_n  (reset_n),
        .Cond     (ctrl.Cond),
        .ALUFlags (ctrl.ALUFlags),
        .FlagW    (flagW),
        .CondEx   (condEx),
        .Flags    (ctrl.Flags)
    );
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench: per-cycle expected controls are queued per instruction and popped each cycle.
module tb_arm_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset_n;

    arm_multicycle_ctrl_if bus();
    arm_multicycle_ctrl dut (.clk(clk), .reset_n(reset_n), .ctrl(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, mw, rw, irw, adr;
        logic [1:0] res;
        logic       srcA;
        logic [1:0] srcB, imm, alu, regSrc;
        logic [3:0] flags;
    } sig_t;

    sig_t  expQ[$];
    sig_t  careQ[$];
    string tagQ[$];
    int    nChecks = 0;
    int    nPass = 0;
    logic [3:0] mFlags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic sig_t observe();
        sig_t s;
        s.pcw = bus.PCWrite;   s.mw = bus.MemWrite; s.rw = bus.RegWrite;
        s.irw = bus.IRWrite;   s.adr = bus.AdrSrc;  s.res = bus.ResultSrc;
        s.srcA = bus.ALUSrcA;  s.srcB = bus.ALUSrcB; s.imm = bus.ImmSrc;
        s.alu = bus.ALUControl; s.regSrc = bus.RegSrc; s.flags = bus.Flags;
        return s;
    endfunction

    // ARM style: base test on Cond[3:1], Cond[0] inverts, 1111 never.
    function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (cond[0] && cond[3:1] != 3'd7) r = ~r;
        if (cond == 4'hF) r = 1'b0;
        return r;
    endfunction

    function automatic logic [1:0] aluExp(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    // step: 0 fetch,1 decode,2 memadr,3 memread,4 memwb,5 memwrite,6 execR,7 execI,8 aluwb,9 branch
    task automatic pushStep(input string nm, input int cyc, input int step, input logic ex,
                            input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        sig_t e, c;
        e = '0; c = '0;
        c.pcw = 1'b1; c.mw = 1'b1; c.rw = 1'b1; c.irw = 1'b1;
        c.flags = 4'hF; e.flags = mFlags;
        case (step)
            0: begin
                e.irw = 1'b1; e.pcw = 1'b1; c.adr = 1'b1;
                e.res = 2'b10; c.res = 2'b11; e.srcA = 1'b1; c.srcA = 1'b1;
                e.srcB = 2'b10; c.srcB = 2'b11; c.alu = 2'b11;
            end
            1: begin
                e.res = 2'b10; c.res = 2'b11; e.srcA = 1'b1; c.srcA = 1'b1;
                e.srcB = 2'b10; c.srcB = 2'b11;
                if (op != 2'b11) begin e.imm = op + 2'b01; c.imm = 2'b11; end
                e.regSrc = {op == 2'b01 && !funct[0], op == 2'b10}; c.regSrc = 2'b11;
            end
            2: begin
                c.srcA = 1'b1; e.srcB = 2'b01; c.srcB = 2'b11; c.alu = 2'b11;
                e.imm = 2'b10; c.imm = 2'b11;
            end
            3: begin e.adr = 1'b1; c.adr = 1'b1; c.res = 2'b11; end
            4: begin
                e.res = 2'b01; c.res = 2'b11; e.rw = ex; e.pcw = ex & (rd == 4'hF);
            end
            5: begin e.adr = 1'b1; c.adr = 1'b1; e.mw = ex; end
            6: begin c.srcA = 1'b1; c.srcB = 2'b11; e.alu = aluExp(funct[4:1]); c.alu = 2'b11; end
            7: begin
                c.srcA = 1'b1; e.srcB = 2'b01; c.srcB = 2'b11; e.imm = 2'b01; c.imm = 2'b11;
                e.alu = aluExp(funct[4:1]); c.alu = 2'b11;
            end
            8: begin
                c.res = 2'b11; e.rw = ex & (funct[4:1] != 4'b1010);
                e.pcw = e.rw & (rd == 4'hF);
            end
            default: begin
                c.srcA = 1'b1; e.srcB = 2'b01; c.srcB = 2'b11; e.imm = 2'b11; c.imm = 2'b11;
                e.res = 2'b10; c.res = 2'b11; e.pcw = ex;
            end
        endcase
        expQ.push_back(e);
        careQ.push_back(c);
        tagQ.push_back($sformatf("%s.c%0d", nm, cyc));
    endtask

    task automatic expectInstr(input string nm, input logic [3:0] cond, input logic [1:0] op,
                               input logic [5:0] funct, input logic [3:0] rd,
                               input logic [3:0] aluFlags, output int n);
        logic ex;
        logic [3:0] cmd;
        ex = condHolds(cond, mFlags);
        cmd = funct[4:1];
        pushStep(nm, 1, 0, ex, op, funct, rd);
        pushStep(nm, 2, 1, ex, op, funct, rd);
        n = 2;
        case (op)
            2'b01: begin
                pushStep(nm, 3, 2, ex, op, funct, rd);
                if (funct[0]) begin
                    pushStep(nm, 4, 3, ex, op, funct, rd);
                    pushStep(nm, 5, 4, ex, op, funct, rd);
                    n = 5;
                end else begin
                    pushStep(nm, 4, 5, ex, op, funct, rd);
                    n = 4;
                end
            end
            2'b00: begin
                pushStep(nm, 3, funct[5] ? 7 : 6, ex, op, funct, rd);
                pushStep(nm, 4, 8, ex, op, funct, rd);
                n = 4;
                if (funct[0] && ex) begin
                    if (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010})
                        mFlags[3:2] = aluFlags[3:2];
                    if (cmd inside {4'b0100, 4'b0010, 4'b1010})
                        mFlags[1:0] = aluFlags[1:0];
                end
            end
            2'b10: begin
                pushStep(nm, 3, 9, ex, op, funct, rd);
                n = 3;
            end
            default: ;
        endcase
    endtask

    task automatic runCycles(input int n);
        sig_t e, c;
        string t;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (expQ.size() == 0) begin
                check("sb_underflow", 32'(expQ.size()), 32'd1);
            end else begin
                e = expQ.pop_front();
                c = careQ.pop_front();
                t = tagQ.pop_front();
                check(t, 32'(observe() & c), 32'(e & c));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runInstr(input string nm, input logic [3:0] cond, input logic [1:0] op,
                            input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] aluFlags);
        int n;
        expectInstr(nm, cond, op, funct, rd, aluFlags, n);
        bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.ALUFlags = aluFlags;
        runCycles(n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
        mFlags = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enables", 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}), 32'd0);
        check("rst_flags", 32'(bus.Flags), 32'd0);
        reset_n = 1'b1;

        runInstr("ADDS_I",   4'hE, 2'b00, 6'b101001, 4'd1, 4'b0100);
        runInstr("LDR",      4'hE, 2'b01, 6'b011001, 4'd2, 4'b1111);
        runInstr("SUBS_R",   4'hE, 2'b00, 6'b000101, 4'd3, 4'b1010);
        runInstr("STR_EQ",   4'h0, 2'b01, 6'b011000, 4'd4, 4'b0000);
        runInstr("B_EQ_nt",  4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
        runInstr("ANDS_R",   4'hE, 2'b00, 6'b000001, 4'd5, 4'b0100);
        runInstr("B_EQ_t",   4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
        runInstr("UNDEF",    4'hF, 2'b11, 6'b111111, 4'hF, 4'b1111);
        runInstr("CMP_I",    4'hE, 2'b00, 6'b110101, 4'd0, 4'b0011);
        runInstr("ADDS_EQx", 4'h0, 2'b00, 6'b101001, 4'd6, 4'b1111);
        runInstr("ORR_PC",   4'hE, 2'b00, 6'b111000, 4'hF, 4'b0000);
        runInstr("UNK_S",    4'hE, 2'b00, 6'b111111, 4'd7, 4'b1100);
        runInstr("LDR_GEx",  4'hA, 2'b01, 6'b011001, 4'd8, 4'b0000);
        runInstr("STR_LT",   4'hB, 2'b01, 6'b011000, 4'd9, 4'b0000);
        runInstr("LDR_PC",   4'hE, 2'b01, 6'b011001, 4'hF, 4'b0000);
        check("flags_before_rst", 32'(bus.Flags), 32'(mFlags));

        // Reset asserted while the controller sits in MEMADR.
        expectInstr("LDR_RST", 4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, n);
        bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd2;
        runCycles(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_enables", 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}), 32'd0);
        check("midrst_flags", 32'(bus.Flags), 32'd0);
        check("midrst_fetch_sel", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc}), 32'b11010);
        expQ.delete(); careQ.delete(); tagQ.delete();
        mFlags = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        runInstr("ADD_AFTER", 4'hE, 2'b00, 6'b101000, 4'd1, 4'b1111);
        check("sb_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
